// File: rtl/booth_pkg.sv
// Shared constants for the radix-8 Booth multiplier family.
//   ACC_W_DEF / CNT_W_DEF : default accumulator and product-count widths
//   StIdle / StAcc        : MAC accumulator FSM encodings (no open frame / frame open)
package booth_pkg;

  localparam int unsigned ACC_W_DEF = 24;
  localparam int unsigned CNT_W_DEF = 8;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StAcc  = 1'b1;

endpackage

// File: rtl/booth_acc_add.sv
// Extend-and-add datapath for the MAC accumulator.
//   acc  : running sum, two's complement, ACC_W bits
//   p    : 16-bit product from the multiplier
//   p_sm : signedness tag; 2'b00 = unsigned operands (zero-extend), else sign-extend
//   sum  : acc + ext(p), wrapping
//   ovf  : signed overflow of that addition
module booth_acc_add
  import booth_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [15:0]      p,
  input  logic [1:0]       p_sm,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] p_ext;

  always_comb begin
    if (p_sm == 2'b00) begin
      p_ext = {{(ACC_W-16){1'b0}}, p};
    end else begin
      p_ext = {{(ACC_W-16){p[15]}}, p};
    end
    sum = acc + p_ext;
    // Overflow only when both operands share a sign and the result's sign differs.
    ovf = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  end

endmodule

// File: rtl/booth_mac_accumulator.sv
// Frame accumulator behind the radix-8 Booth multiplier. Sums every valid product of a
// frame (never stalls the input) and presents the sum, product count and overflow flag
// on a valid/ready result port one cycle after the frame's last product.
//   clk, rst        : clock; asynchronous active-high reset
//   p_v/p/p_sm      : product valid, product, signedness tag
//   p_last          : marks the last product of a frame
//   clr             : drop the open frame (wins over p_v on the same cycle)
//   r_valid/r_ready : result handshake
//   r_acc/r_cnt/r_ovf : frame sum, product count, overflow
//   overrun         : sticky; an unconsumed result was overwritten
module booth_mac_accumulator
  import booth_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_v,
  input  logic [15:0]      p,
  input  logic [1:0]       p_sm,
  input  logic             p_last,
  input  logic             clr,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [ACC_W-1:0] r_acc,
  output logic [CNT_W-1:0] r_cnt,
  output logic             r_ovf,
  output logic             overrun
);

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             r_valid_q, r_valid_d;
  logic [ACC_W-1:0] r_acc_q, r_acc_d;
  logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
  logic             r_ovf_q, r_ovf_d;
  logic             overrun_q, overrun_d;

  logic [ACC_W-1:0] add_acc;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf_new;
  logic             load;

  // Feeding zero in IDLE makes the first product of a frame a plain load through the same adder.
  assign add_acc = (state_q == StAcc) ? acc_q : '0;

  booth_acc_add #(
    .ACC_W(ACC_W)
  ) u_add (
    .acc (add_acc),
    .p   (p),
    .p_sm(p_sm),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_comb begin
    if (state_q == StIdle) begin
      cnt_inc = CNT_W'(1);
    end else if (&cnt_q) begin
      cnt_inc = cnt_q;
    end else begin
      cnt_inc = cnt_q + CNT_W'(1);
    end
    ovf_new = (state_q == StAcc) && (ovf_q || add_ovf);
    load    = p_v && p_last && !clr;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    r_acc_d   = r_acc_q;
    r_cnt_d   = r_cnt_q;
    r_ovf_d   = r_ovf_q;
    r_valid_d = r_valid_q;
    overrun_d = overrun_q;

    if (clr) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (p_v) begin
      if (p_last) begin
        state_d = StIdle;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        r_acc_d = add_sum;
        r_cnt_d = cnt_inc;
        r_ovf_d = ovf_new;
      end else begin
        state_d = StAcc;
        acc_d   = add_sum;
        cnt_d   = cnt_inc;
        ovf_d   = ovf_new;
      end
    end

    // A load on the handshake edge counts as consume-then-reload.
    if (load) begin
      r_valid_d = 1'b1;
    end else if (r_valid_q && r_ready) begin
      r_valid_d = 1'b0;
    end
    overrun_d = overrun_q || (load && r_valid_q && !r_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      r_valid_q <= 1'b0;
      r_acc_q   <= '0;
      r_cnt_q   <= '0;
      r_ovf_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      r_valid_q <= r_valid_d;
      r_acc_q   <= r_acc_d;
      r_cnt_q   <= r_cnt_d;
      r_ovf_q   <= r_ovf_d;
      overrun_q <= overrun_d;
    end
  end

  assign r_valid = r_valid_q;
  assign r_acc   = r_acc_q;
  assign r_cnt   = r_cnt_q;
  assign r_ovf   = r_ovf_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Directed bench for booth_mac_accumulator: a table of short frames plus hand-written
// sequences for long frames, count saturation, overrun, clr, reset and handshake overlap.
module tb_booth_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p_v = 1'b0;
  logic [15:0] p = '0;
  logic [1:0]  p_sm = '0;
  logic        p_last = 1'b0;
  logic        clr = 1'b0;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic [23:0] r_acc;
  logic [7:0]  r_cnt;
  logic        r_ovf;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  booth_mac_accumulator #(
    .ACC_W(24),
    .CNT_W(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .p_v    (p_v),
    .p      (p),
    .p_sm   (p_sm),
    .p_last (p_last),
    .clr    (clr),
    .r_valid(r_valid),
    .r_ready(r_ready),
    .r_acc  (r_acc),
    .r_cnt  (r_cnt),
    .r_ovf  (r_ovf),
    .overrun(overrun)
  );

  typedef struct {
    int              n;
    logic [2:0][15:0] pv;
    logic [1:0]      sm;
    logic [23:0]     exp_acc;
    logic [7:0]      exp_cnt;
    logic            exp_ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic prod(input logic [15:0] pv, input logic [1:0] sm, input logic last);
    p_v    = 1'b1;
    p      = pv;
    p_sm   = sm;
    p_last = last;
    tick();
    p_v    = 1'b0;
    p_last = 1'b0;
  endtask

  task automatic consume(input string name);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    chk(name, {31'b0, r_valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{n: 3, pv: {16'h0064, 16'hFFF4, 16'h0006}, sm: 2'b11,
                exp_acc: 24'h00005E, exp_cnt: 8'd3, exp_ovf: 1'b0};
    vecs[1] = '{n: 1, pv: {16'h0, 16'h0, 16'hFE01}, sm: 2'b00,
                exp_acc: 24'h00FE01, exp_cnt: 8'd1, exp_ovf: 1'b0};
    vecs[2] = '{n: 1, pv: {16'h0, 16'h0, 16'hFE01}, sm: 2'b11,
                exp_acc: 24'hFFFE01, exp_cnt: 8'd1, exp_ovf: 1'b0};
    vecs[3] = '{n: 2, pv: {16'h0, 16'h8000, 16'h8000}, sm: 2'b01,
                exp_acc: 24'hFF0000, exp_cnt: 8'd2, exp_ovf: 1'b0};
    vecs[4] = '{n: 3, pv: {16'h0001, 16'h7FFF, 16'h7FFF}, sm: 2'b00,
                exp_acc: 24'h00FFFF, exp_cnt: 8'd3, exp_ovf: 1'b0};
    vecs[5] = '{n: 2, pv: {16'h0, 16'h0001, 16'hFFFF}, sm: 2'b10,
                exp_acc: 24'h000000, exp_cnt: 8'd2, exp_ovf: 1'b0};

    // Reset state
    #12;
    chk("rst_r_valid", {31'b0, r_valid}, 32'd0);
    chk("rst_r_acc", {8'b0, r_acc}, 32'd0);
    chk("rst_r_cnt", {24'b0, r_cnt}, 32'd0);
    chk("rst_overrun", {31'b0, overrun}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Table frames: result must appear exactly one cycle after the last product
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        chk($sformatf("v%0d_valid_early", i), {31'b0, r_valid}, 32'd0);
        prod(vecs[i].pv[k], vecs[i].sm, (k == vecs[i].n - 1));
      end
      chk($sformatf("v%0d_valid", i), {31'b0, r_valid}, 32'd1);
      chk($sformatf("v%0d_acc", i), {8'b0, r_acc}, {8'b0, vecs[i].exp_acc});
      chk($sformatf("v%0d_cnt", i), {24'b0, r_cnt}, {24'b0, vecs[i].exp_cnt});
      chk($sformatf("v%0d_ovf", i), {31'b0, r_ovf}, {31'b0, vecs[i].exp_ovf});
      consume($sformatf("v%0d_consume", i));
    end

    // 130 * 0xFE01 = 0x80FC82: exceeds the signed 24-bit range on the 130th add
    for (int k = 0; k < 130; k++) prod(16'hFE01, 2'b00, (k == 129));
    chk("long_acc", {8'b0, r_acc}, 32'h0080FC82);
    chk("long_cnt", {24'b0, r_cnt}, 32'd130);
    chk("long_ovf", {31'b0, r_ovf}, 32'd1);
    consume("long_consume");

    // Count saturates at 255
    for (int k = 0; k < 301; k++) prod(16'h0000, 2'b00, (k == 300));
    chk("sat_cnt", {24'b0, r_cnt}, 32'd255);
    chk("sat_ovf", {31'b0, r_ovf}, 32'd0);
    consume("sat_consume");

    // p_v=0 cycles ignored even with p_last set
    prod(16'h0002, 2'b00, 1'b0);
    p = 16'hFFFF; p_last = 1'b1; p_sm = 2'b11;
    tick();
    p_last = 1'b0;
    chk("idle_cycle_valid", {31'b0, r_valid}, 32'd0);
    prod(16'h0003, 2'b00, 1'b1);
    chk("idle_cycle_acc", {8'b0, r_acc}, 32'd5);
    chk("idle_cycle_cnt", {24'b0, r_cnt}, 32'd2);
    consume("idle_cycle_consume");

    // Back-to-back single-product frames with no ready: overwrite and flag overrun
    prod(16'h0001, 2'b00, 1'b1);
    chk("ovr_first_overrun", {31'b0, overrun}, 32'd0);
    prod(16'h0002, 2'b00, 1'b1);
    chk("ovr_valid", {31'b0, r_valid}, 32'd1);
    chk("ovr_acc", {8'b0, r_acc}, 32'd2);
    chk("ovr_overrun", {31'b0, overrun}, 32'd1);
    consume("ovr_consume");
    chk("ovr_sticky", {31'b0, overrun}, 32'd1);

    // clr with p_v mid-frame drops the frame and that product
    prod(16'h0009, 2'b00, 1'b0);
    clr = 1'b1;
    prod(16'h0020, 2'b00, 1'b0);
    clr = 1'b0;
    prod(16'h0005, 2'b00, 1'b1);
    chk("clr_acc", {8'b0, r_acc}, 32'd5);
    chk("clr_cnt", {24'b0, r_cnt}, 32'd1);
    chk("clr_overrun", {31'b0, overrun}, 32'd1);

    // Result left pending; rst mid-frame clears everything immediately
    prod(16'h0011, 2'b00, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_valid", {31'b0, r_valid}, 32'd0);
    chk("rstmid_acc", {8'b0, r_acc}, 32'd0);
    chk("rstmid_cnt", {24'b0, r_cnt}, 32'd0);
    chk("rstmid_overrun", {31'b0, overrun}, 32'd0);
    tick();
    rst = 1'b0;
    prod(16'h0003, 2'b00, 1'b0);
    prod(16'h0004, 2'b00, 1'b1);
    chk("rstmid_new_acc", {8'b0, r_acc}, 32'd7);
    chk("rstmid_new_cnt", {24'b0, r_cnt}, 32'd2);
    consume("rstmid_consume");

    // Handshake and new load on the same edge: no overrun, valid stays high
    prod(16'h0003, 2'b00, 1'b1);
    r_ready = 1'b1;
    prod(16'h0004, 2'b00, 1'b1);
    r_ready = 1'b0;
    chk("both_valid", {31'b0, r_valid}, 32'd1);
    chk("both_acc", {8'b0, r_acc}, 32'd4);
    chk("both_overrun", {31'b0, overrun}, 32'd0);
    consume("both_consume");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
